// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states,
// opcodes, ALU operation / operand-B selects and the one-hot opcode class.
package ctrl_pkg;

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_BR   = 3'd5,
        S_BRT  = 3'd6,
        S_HALT = 3'd7
    } state_e;

    localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_I      = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_ECALL  = 7'b1110011;

    localparam logic [SEL_W-1:0] ALU_ADD    = 2'b00;
    localparam logic [SEL_W-1:0] ALU_BRANCH = 2'b01;
    localparam logic [SEL_W-1:0] ALU_FUNCT  = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;

    // All-zero class means an unrecognised opcode.
    typedef struct packed {
        logic r;
        logic i;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic ecall;
    } op_class_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational decode of the instruction opcode into a one-hot class.
module opcode_class_decode
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output op_class_t        op_class
);

    always_comb begin
        op_class = '0;
        case (opcode)
            OPC_R:      op_class.r      = 1'b1;
            OPC_I:      op_class.i      = 1'b1;
            OPC_LOAD:   op_class.load   = 1'b1;
            OPC_STORE:  op_class.store  = 1'b1;
            OPC_BRANCH: op_class.branch = 1'b1;
            OPC_JAL:    op_class.jal    = 1'b1;
            OPC_JALR:   op_class.jalr   = 1'b1;
            OPC_ECALL:  op_class.ecall  = 1'b1;
            default:    op_class        = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences IF/ID/EX/MEM/WB/BR/BRT/HALT and decodes
// every datapath select and write enable from the state register.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             bcond,
    input  logic             halt_req,
    input  logic             mem_ready,
    output logic             ior_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [SEL_W-1:0] alu_src_b,
    output logic [SEL_W-1:0] alu_op,
    output logic             pc_source,
    output logic             pc_write,
    output logic             is_halted
);

    state_e    state_q;
    state_e    state_d;
    op_class_t cls;

    opcode_class_decode u_decode (
        .opcode   (opcode),
        .op_class (cls)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ior_d      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        pc_source  = 1'b0;
        pc_write   = 1'b0;
        is_halted  = 1'b0;

        case (state_q)
            S_IF: begin
                ior_d    = 1'b1;
                mem_read = 1'b1;
                ir_write = mem_ready;
                if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                alu_src_b = SRCB_FOUR;
                if (cls.ecall && halt_req) begin
                    state_d = S_HALT;
                end else if (cls.ecall || cls == '0) begin
                    pc_write  = 1'b1;
                    pc_source = 1'b1;
                    state_d   = S_IF;
                end else if (cls.branch) begin
                    state_d = S_BR;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (cls.r) begin
                    alu_src_b = SRCB_RS2;
                    alu_op    = ALU_FUNCT;
                    state_d   = S_WB;
                end else if (cls.i) begin
                    alu_op  = ALU_FUNCT;
                    state_d = S_WB;
                end else if (cls.load || cls.store) begin
                    state_d = S_MEM;
                end else if (cls.jal || cls.jalr) begin
                    alu_src_a = cls.jalr;
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    pc_source = 1'b1;
                    state_d   = S_IF;
                end else begin
                    state_d = S_IF;
                end
            end
            S_MEM: begin
                mem_read  = cls.load;
                mem_write = cls.store;
                if (mem_ready && cls.store) begin
                    alu_src_b = SRCB_FOUR;
                    pc_source = 1'b1;
                    pc_write  = 1'b1;
                    state_d   = S_IF;
                end else begin
                    // Recompute rs1+imm so ALUOut, and thus the address, holds across stalls.
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    if (mem_ready) state_d = S_WB;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = cls.load;
                alu_src_b  = SRCB_FOUR;
                pc_source  = 1'b1;
                pc_write   = 1'b1;
                state_d    = S_IF;
            end
            S_BR: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_BRANCH;
                if (bcond) begin
                    state_d = S_BRT;
                end else begin
                    pc_write = 1'b1;
                    state_d  = S_IF;
                end
            end
            S_BRT: begin
                alu_src_b = SRCB_IMM;
                pc_source = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_IF;
            end
            S_HALT: begin
                is_halted = 1'b1;
            end
            default: begin
                state_d = S_IF;
            end
        endcase

        // No architectural write may fire in a reset cycle.
        if (reset) begin
            pc_write  = 1'b0;
            reg_write = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: drives random instructions through a small
// behavioural datapath model and checks architectural effects and latency.
module tb_multicycle_ctrl;

    localparam int K_R    = 0;
    localparam int K_I    = 1;
    localparam int K_LD   = 2;
    localparam int K_ST   = 3;
    localparam int K_BR   = 4;
    localparam int K_JAL  = 5;
    localparam int K_JALR = 6;
    localparam int K_EC   = 7;
    localparam int K_UNK  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       bcond = 1'b0;
    logic       halt_req = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ior_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg;
    logic       alu_src_a, pc_source, pc_write, is_halted;
    logic [1:0] alu_src_b, alu_op;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .bcond      (bcond),
        .halt_req   (halt_req),
        .mem_ready  (mem_ready),
        .ior_d      (ior_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .pc_write   (pc_write),
        .is_halted  (is_halted)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Datapath model state and per-instruction observations.
    logic [31:0] pc = 32'h1000, aluout = '0, mdr = '0, rs1, rs2, imm, exp_addr, rd_val;
    logic [6:0]  nxt_opcode;
    logic        nxt_bc, nxt_hq, pend = 1'b0, cur_ld, cur_st;
    int if_wait, mem_wait, n_cyc, ir_cnt, rf_cnt, wr_cnt, pc_cnt, f_cyc, d_cyc;
    int bad_sel, bad_addr, bad_strobe, halt_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] addr);
        return addr * 32'd3 + 32'h1234;
    endfunction

    function automatic logic [6:0] opc_of(input int kind);
        case (kind)
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_LD:    return 7'b0000011;
            K_ST:    return 7'b0100011;
            K_BR:    return 7'b1100011;
            K_JAL:   return 7'b1101111;
            K_JALR:  return 7'b1100111;
            K_EC:    return 7'b1110011;
            default: return 7'b1111111;
        endcase
    endfunction

    // Effect of one clock edge on the datapath, from the sampled controls.
    task automatic model_step();
        logic [31:0] a, b, alu, addr;
        n_cyc++;
        a = alu_src_a ? rs1 : pc;
        case (alu_src_b)
            2'b00:   b = rs2;
            2'b01:   b = 32'd4;
            2'b10:   b = imm;
            default: begin b = '0; bad_sel++; end
        endcase
        case (alu_op)
            2'b00:   alu = a + b;
            2'b01:   alu = a - b;
            2'b10:   alu = a ^ b;
            default: begin alu = '0; bad_sel++; end
        endcase
        addr = ior_d ? pc : aluout;
        if (mem_read && ior_d) f_cyc++;
        if (ior_d && mem_write) bad_strobe++;
        if (!ior_d && (mem_read || mem_write)) begin
            d_cyc++;
            if (addr != exp_addr) bad_addr++;
            if (mem_read != cur_ld || mem_write != cur_st) bad_strobe++;
        end
        if (mem_read && mem_ready && !ior_d) mdr = memfn(addr);
        if (ir_write) begin
            ir_cnt++;
            if (!(mem_read && ior_d && mem_ready)) bad_strobe++;
        end
        if (mem_write && mem_ready) wr_cnt++;
        if (reg_write) begin
            rf_cnt++;
            rd_val = mem_to_reg ? mdr : aluout;
        end
        if (pc_write) begin
            pc_cnt++;
            pc = pc_source ? alu : aluout;
        end
        aluout = alu;
        if (is_halted) halt_cyc++;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (pend) begin
            opcode   = nxt_opcode;
            bcond    = nxt_bc;
            halt_req = nxt_hq;
            pend     = 1'b0;
        end
        if (mem_read && ior_d) begin
            mem_ready = (if_wait == 0);
            if (if_wait > 0) if_wait--;
        end else if (!ior_d && (mem_read || mem_write)) begin
            mem_ready = (mem_wait == 0);
            if (mem_wait > 0) mem_wait--;
        end else begin
            mem_ready = 1'($urandom);
        end
        @(negedge clk);
        model_step();
    endtask

    task automatic apply_reset(input string tag);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check({tag, "_we_in_reset"}, 32'({pc_write, reg_write, ir_write, mem_write}), 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        check({tag, "_post_reset"},
              32'({ior_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg, alu_src_a,
                   alu_src_b, alu_op, pc_source, pc_write, is_halted}),
              32'(14'b11_0000_0000_0000));
    endtask

    task automatic start_instr(input int kind, input logic bc, input logic hq, input int ifw, input int memw);
        rs1 = $urandom;
        rs2 = $urandom;
        imm = $urandom;
        nxt_opcode = opc_of(kind);
        nxt_bc = bc;
        nxt_hq = hq;
        pend = 1'b1;
        if_wait = ifw;
        mem_wait = memw;
        cur_ld = (kind == K_LD);
        cur_st = (kind == K_ST);
        exp_addr = rs1 + imm;
        n_cyc = 0; ir_cnt = 0; rf_cnt = 0; wr_cnt = 0; pc_cnt = 0; f_cyc = 0; d_cyc = 0;
        bad_sel = 0; bad_addr = 0; bad_strobe = 0; halt_cyc = 0; rd_val = '0;
    endtask

    task automatic run_instr(input int kind, input logic bc, input logic hq, input int ifw, input int memw);
        logic [31:0] pc0, exp_pc, exp_rd;
        int exp_cyc, exp_rf, done_cyc;
        logic halt_exp, mem_op;
        string t;
        start_instr(kind, bc, hq, ifw, memw);
        t = $sformatf("k%0d", kind);
        pc0 = pc;
        halt_exp = (kind == K_EC) && hq;
        mem_op = cur_ld || cur_st;
        exp_pc = pc0 + 32'd4;
        exp_rd = '0;
        exp_rf = 0;
        exp_cyc = 4;
        case (kind)
            K_R:    begin exp_rd = rs1 ^ rs2; exp_rf = 1; end
            K_I:    begin exp_rd = rs1 ^ imm; exp_rf = 1; end
            K_LD:   begin exp_cyc = 5; exp_rd = memfn(rs1 + imm); exp_rf = 1; end
            K_ST:   exp_cyc = 4;
            K_BR:   begin exp_cyc = bc ? 4 : 3; if (bc) exp_pc = pc0 + imm; end
            K_JAL:  begin exp_cyc = 3; exp_pc = pc0 + imm; exp_rd = pc0 + 32'd4; exp_rf = 1; end
            K_JALR: begin exp_cyc = 3; exp_pc = rs1 + imm; exp_rd = pc0 + 32'd4; exp_rf = 1; end
            K_EC:   begin exp_cyc = hq ? 3 : 2; if (hq) exp_pc = pc0; end
            default: exp_cyc = 2;
        endcase
        exp_cyc += ifw + (mem_op ? memw : 0);

        do cycle(); while (pc_cnt == 0 && halt_cyc == 0 && n_cyc < 40);
        done_cyc = n_cyc;
        if (halt_exp) begin
            for (int i = 0; i < 5; i++) cycle();
        end

        check({t, "_cycles"}, 32'(done_cyc), 32'(exp_cyc));
        check({t, "_pc"}, pc, exp_pc);
        check({t, "_pc_writes"}, 32'(pc_cnt), halt_exp ? 32'd0 : 32'd1);
        check({t, "_ir_writes"}, 32'(ir_cnt), 32'd1);
        check({t, "_reg_writes"}, 32'(rf_cnt), 32'(exp_rf));
        if (exp_rf != 0) check({t, "_rd"}, rd_val, exp_rd);
        check({t, "_mem_writes"}, 32'(wr_cnt), 32'(cur_st));
        check({t, "_fetch_cycles"}, 32'(f_cyc), 32'(1 + ifw));
        check({t, "_data_cycles"}, 32'(d_cyc), mem_op ? 32'(1 + memw) : 32'd0);
        check({t, "_bad_sel"}, 32'(bad_sel), 32'd0);
        check({t, "_data_addr"}, 32'(bad_addr), 32'd0);
        check({t, "_strobes"}, 32'(bad_strobe), 32'd0);
        check({t, "_halt_cycles"}, 32'(halt_cyc), halt_exp ? 32'd6 : 32'd0);
    endtask

    initial begin
        int kind;
        apply_reset("init");

        run_instr(K_R,    1'b0, 1'b0, 0, 0);
        run_instr(K_LD,   1'b0, 1'b0, 0, 2);
        run_instr(K_BR,   1'b0, 1'b0, 0, 0);
        run_instr(K_BR,   1'b1, 1'b0, 0, 0);
        run_instr(K_JAL,  1'b0, 1'b1, 0, 0);
        run_instr(K_JALR, 1'b1, 1'b0, 1, 0);
        run_instr(K_I,    1'b0, 1'b0, 2, 0);
        run_instr(K_ST,   1'b0, 1'b0, 0, 0);
        run_instr(K_ST,   1'b1, 1'b1, 1, 3);
        run_instr(K_EC,   1'b0, 1'b0, 0, 0);
        run_instr(K_UNK,  1'b0, 1'b1, 0, 0);

        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 8));
            run_instr(kind, 1'($urandom), (kind == K_EC) ? 1'b0 : 1'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        run_instr(K_EC, 1'b0, 1'b1, 1, 0);
        apply_reset("halt");
        run_instr(K_R, 1'b1, 1'b0, 0, 0);

        // Reset arriving while a store is waiting in MEM.
        start_instr(K_ST, 1'b0, 1'b0, 0, 100);
        do cycle(); while (!(!ior_d && mem_write) && n_cyc < 20);
        check("store_reached_mem", 32'(!ior_d && mem_write), 32'd1);
        apply_reset("mid_store");
        run_instr(K_LD, 1'b0, 1'b0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the RISC-V datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states. Drives every datapath select and write enable: memory-address select, ALU A/B selects, PC source, register write-data select, ALU op. Waits on a memory-ready handshake in fetch and memory states.

## Interface
- No parameters.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; forces state to IF
- opcode  in  7  IR[6:0], stable from the cycle after ir_write
- bcond  in  1  ALU branch-condition result, combinational
- halt_req  in  1  ECALL halt condition from the datapath (x17 == 10)
- mem_ready  in  1  memory completed the current read/write this cycle
- ior_d  out  1  1 = memory address is PC, 0 = ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- ir_write  out  1  latch IR
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  1 = write MDR, 0 = write ALUOut register
- alu_src_a  out  1  1 = rs1, 0 = PC
- alu_src_b  out  2  00 rs2, 01 const 4, 10 imm; 11 never driven
- alu_op  out  2  ADD=00, BRANCH=01, FUNCT=10
- pc_source  out  1  1 = combinational ALU result, 0 = ALUOut register
- pc_write  out  1  PC write enable
- is_halted  out  1  high in HALT

## Operation
- Moore outputs decode from the 3-bit state register, except where qualified by mem_ready/bcond/opcode. Unlisted outputs are 0. Default alu_op=ADD.
- The datapath latches ALUOut every cycle and MDR when mem_read & mem_ready. JALR target bit 0 is cleared in the datapath.
- IF: ior_d=1, mem_read=1, ir_write=mem_ready. Go to ID on mem_ready, else stay in IF.
- ID: a=0, b=01 (ALUOut <= PC+4).
  - ECALL with halt_req: go to HALT.
  - ECALL without halt_req, or unknown opcode: pc_write=1, pc_source=1, go to IF.
  - Branch: go to BR.
  - Otherwise: go to EX.
- EX, by opcode class:
  - R-type: a=1, b=00, FUNCT. Go to WB.
  - I-arith: a=1, b=10, FUNCT. Go to WB.
  - Load/store: a=1, b=10, ADD. Go to MEM.
  - JAL: a=0, b=10. JALR: a=1, b=10. Both also assert reg_write=1 (mem_to_reg=0 writes PC+4 held in ALUOut), pc_write=1, pc_source=1, and go to IF.
- MEM: ior_d=0; mem_read=load, mem_write=store.
  - Without mem_ready: stay in MEM.
  - Load with mem_ready: go to WB.
  - Store with mem_ready: a=0, b=01, pc_source=1, pc_write=1, go to IF.
- WB: reg_write=1, mem_to_reg=load; a=0, b=01, pc_source=1, pc_write=1. Go to IF.
- BR: a=1, b=00, alu_op=BRANCH.
  - bcond=0: pc_write=1, pc_source=0 (PC <= PC+4 from ALUOut), go to IF.
  - bcond=1: go to BRT.
- BRT: a=0, b=10, pc_source=1, pc_write=1. Go to IF.
- HALT: all outputs 0 except is_halted=1. Left only by reset.

## Timing
- Reset: state=IF on the next edge. While reset is high, pc_write, reg_write, ir_write and mem_write are forced to 0. After reset: ior_d=1, mem_read=1, all others 0.
- Latency with mem_ready=1:
  - R-type / I-arith: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles not taken, 4 taken.
  - JAL / JALR: 3 cycles.
  - ECALL: 2 cycles.
- Each cycle mem_ready is low in IF or MEM adds exactly 1 cycle. mem_write and mem_read stay asserted and the address stays stable throughout.
- Reset mid-instruction: no write enable fires in the reset cycle. Fetch restarts.
- mem_ready asserted outside IF/MEM is ignored.

## Structure
- Package ctrl_pkg holds:
  - state encodings IF=0, ID=1, EX=2, MEM=3, WB=4, BR=5, BRT=6, HALT=7;
  - opcode constants: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, ECALL 1110011;
  - alu_op and alu_src_b encodings.
- One natural sub-module: opcode_class_decode, combinational opcode to one-hot class.

## Test plan
- R-type (0110011), mem_ready=1: states IF,ID,EX,WB. In EX: a=1, b=00, alu_op=10. In WB: reg_write=1, mem_to_reg=0, pc_write=1.
- Load with mem_ready low 2 cycles in MEM: 7 cycles total. In MEM: ior_d=0, mem_read=1 held. In WB: mem_to_reg=1.
- Branch with bcond=0: pc_write=1 and pc_source=0 in BR, 3 cycles. With bcond=1: BRT with a=0, b=10, pc_source=1, 4 cycles.
- JAL: reg_write=1 and pc_write=1 in the same EX cycle with a=0, b=10. Back in IF after 3 cycles.
- ECALL with halt_req=1: HALT after ID, is_halted=1 indefinitely. ECALL with halt_req=0: pc_write in ID.
- Reset asserted during MEM of a store: mem_write=0 that cycle, then IF with ior_d=1, mem_read=1.
